// File: rtl/io_bus_master.sv
// Initiator for a bank of io_register instances: takes single host read/write
// requests, drives a one-hot enable/write/data bus and returns a response pulse.
module io_bus_master #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_error,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [NUM_REGS-1:0]   bus_enable,
  output logic                  bus_write,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  input  logic [DATA_WIDTH-1:0] bus_data_in
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_FETCH,
    RD_CAPT,
    ERR,
    RESP
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [NUM_REGS-1:0]     sel_onehot;
  logic                    accept;
  logic                    out_of_range;

  logic [NUM_REGS-1:0]     enable_next;
  logic                    write_next;
  logic [DATA_WIDTH-1:0]   data_next;
  logic                    rsp_valid_next;
  logic                    rsp_error_next;
  logic [DATA_WIDTH-1:0]   rdata_next;

  assign req_ready    = (state == IDLE);
  assign accept       = req_valid && req_ready;
  assign out_of_range = (int'(req_addr) >= NUM_REGS);

  // The address being decoded is the live request while idle, the captured one afterwards.
  assign sel_addr = (state == IDLE) ? req_addr : addr_q;

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel_onehot[i] = (sel_addr == ADDR_WIDTH'(i));
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_next     = state;
    enable_next    = '0;
    write_next     = 1'b0;
    data_next      = '0;
    rsp_valid_next = 1'b0;
    rsp_error_next = 1'b0;
    rdata_next     = rsp_rdata;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (out_of_range)   state_next = ERR;
          else if (req_write) state_next = WR;
          else                state_next = RD_FETCH;
        end
      end
      WR:       state_next = RESP;
      RD_FETCH: state_next = RD_CAPT;
      RD_CAPT: begin
        state_next = RESP;
        rdata_next = bus_data_in;
      end
      ERR: begin
        state_next     = RESP;
        rdata_next     = '0;
        rsp_error_next = 1'b1;
      end
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    // Bus outputs are registered, so they are decoded from the state being entered.
    unique case (state_next)
      WR: begin
        enable_next = sel_onehot;
        write_next  = 1'b1;
        data_next   = req_wdata;
      end
      RD_FETCH, RD_CAPT: enable_next = sel_onehot;
      RESP:              rsp_valid_next = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      addr_q       <= '0;
      bus_enable   <= '0;
      bus_write    <= 1'b0;
      bus_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_error    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      state        <= state_next;
      if (accept) addr_q <= req_addr;
      bus_enable   <= enable_next;
      bus_write    <= write_next;
      bus_data_out <= data_next;
      rsp_valid    <= rsp_valid_next;
      rsp_error    <= rsp_error_next;
      rsp_rdata    <= rdata_next;
    end
  end

  // Bus contract seen by the attached registers.
  a_enable_onehot: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    $onehot0(bus_enable));
  a_write_has_enable: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    bus_write |-> (bus_enable != '0));
  a_data_quiet: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !bus_write |-> (bus_data_out == '0));
  a_rsp_pulse: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    rsp_valid |=> !rsp_valid);

endmodule

// File: tb/tb_io_bus_master.sv
// Directed and randomised bench for io_bus_master with six behavioural
// io_register models on the bus and a separate expected-memory scoreboard.
module tb_io_bus_master;

  localparam int DW = 32;
  localparam int NR = 6;
  localparam int AW = 3;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic [NR-1:0] bus_enable;
  logic          bus_write;
  logic [DW-1:0] bus_data_out;
  logic [DW-1:0] bus_data_in;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  logic [DW-1:0] reg_mem [NR] = '{default: '0};
  logic [DW-1:0] reg_out [NR] = '{default: '0};
  logic [DW-1:0] exp_mem [NR];
  logic [DW-1:0] last_rdata;

  io_bus_master #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_error    (rsp_error),
    .rsp_rdata    (rsp_rdata),
    .bus_enable   (bus_enable),
    .bus_write    (bus_write),
    .bus_data_out (bus_data_out),
    .bus_data_in  (bus_data_in)
  );

  always #5 clk_in = ~clk_in;

  // io_register models: commit on enable&write, copy to output latch on enable&!write.
  always @(posedge clk_in) begin
    for (int i = 0; i < NR; i++) begin
      if (bus_enable[i]) begin
        if (bus_write) reg_mem[i] <= bus_data_out;
        else           reg_out[i] <= reg_mem[i];
      end
    end
  end

  // Undriven bus shows a junk pattern that the master must never capture.
  always_comb begin
    bus_data_in = 32'hBADC_0FFE;
    for (int i = 0; i < NR; i++) begin
      if (bus_enable[i] && !bus_write) bus_data_in = reg_out[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (mon_on && rst_n_in) begin
      check("onehot_enable", 64'($onehot0(bus_enable)), 64'(1));
      if (!bus_write) check("data_out_quiet", 64'(bus_data_out), 64'(0));
    end
  end

  // One request with full timing/bus checks; called at #1 after an edge.
  task automatic do_req(input string name, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic exp_err,
                        input logic [DW-1:0] exp_rdata);
    int waited;
    int lat;
    int en_cyc;
    int wr_cyc;
    int exp_cycle;
    bit got;
    logic [DW-1:0] exp_rd;
    exp_rd    = (wr && !exp_err) ? last_rdata : exp_rdata;
    exp_cycle = (wr || exp_err) ? 2 : 3;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(posedge clk_in); #1;
      waited++;
    end
    if (!req_ready) begin
      check({name, "_accept_timeout"}, 64'(0), 64'(1));
      req_valid = 1'b0;
      return;
    end
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    lat = 0; en_cyc = 0; wr_cyc = 0; got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (bus_enable != '0) begin
          en_cyc++;
          check({name, "_enable"}, 64'(bus_enable), 64'(6'(1) << addr));
        end
        if (bus_write) begin
          wr_cyc++;
          check({name, "_data_out"}, 64'(bus_data_out), 64'(wdata));
        end
        lat++;
        @(posedge clk_in); #1;
      end
    end
    check({name, "_rsp_cycle"}, 64'(got ? lat + 1 : 99), 64'(exp_cycle));
    if (got) begin
      check({name, "_error"}, 64'(rsp_error), 64'(exp_err));
      check({name, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
      @(posedge clk_in); #1;
      check({name, "_pulse_end"}, 64'(rsp_valid), 64'(0));
      check({name, "_ready_again"}, 64'(req_ready), 64'(1));
    end
    check({name, "_en_cycles"}, 64'(en_cyc), 64'(exp_err ? 0 : (wr ? 1 : 2)));
    check({name, "_wr_cycles"}, 64'(wr_cyc), 64'((wr && !exp_err) ? 1 : 0));
    if (wr && !exp_err) exp_mem[addr] = wdata;
    last_rdata = exp_rd;
  endtask

  typedef struct {
    string         name;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;

    vecs[0] = '{"t1_wr_a2",    1'b1, 3'd2, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1] = '{"t2_rd_a2",    1'b0, 3'd2, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{"t2_rd_a4",    1'b0, 3'd4, 32'h0,         1'b0, 32'h0};
    vecs[3] = '{"t3_rd_a7",    1'b0, 3'd7, 32'h0,         1'b1, 32'h0};
    vecs[4] = '{"t3_wr_a5",    1'b1, 3'd5, 32'hA5A5_5A5A, 1'b0, 32'h0};
    vecs[5] = '{"rd_a5",       1'b0, 3'd5, 32'h0,         1'b0, 32'hA5A5_5A5A};
    vecs[6] = '{"wr_a6_err",   1'b1, 3'd6, 32'h1234_5678, 1'b1, 32'h0};
    vecs[7] = '{"wr_a0",       1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[8] = '{"rd_a0",       1'b0, 3'd0, 32'h0,         1'b0, 32'hFFFF_FFFF};
    vecs[9] = '{"rd_a2_again", 1'b0, 3'd2, 32'h0,         1'b0, 32'hDEAD_BEEF};

    for (int i = 0; i < NR; i++) exp_mem[i] = '0;
    last_rdata = '0;

    // Reset values, observed before any clock edge.
    #2 rst_n_in = 1'b0;
    #1;
    check("rst_enable",   64'(bus_enable),   64'(0));
    check("rst_write",    64'(bus_write),    64'(0));
    check("rst_data_out", 64'(bus_data_out), 64'(0));
    check("rst_rsp_valid",64'(rsp_valid),    64'(0));
    check("rst_rsp_error",64'(rsp_error),    64'(0));
    check("rst_rdata",    64'(rsp_rdata),    64'(0));
    check("rst_ready",    64'(req_ready),    64'(1));
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rst_n_in = 1'b1;
    mon_on = 1'b1;
    @(posedge clk_in); #1;

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_err, vecs[i].exp_rdata);
    end

    // T4: req_valid held across a write followed by a read.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd0; req_wdata = 32'h11;
    check("t4_ready_idle", 64'(req_ready), 64'(1));
    @(posedge clk_in); #1;
    req_write = 1'b0; req_wdata = '0;
    check("t4_busy_wr",   64'(req_ready),  64'(0));
    check("t4_wr_enable", 64'(bus_enable), 64'(6'b000001));
    check("t4_wr_strobe", 64'(bus_write),  64'(1));
    @(posedge clk_in); #1;
    check("t4_busy_resp",  64'(req_ready), 64'(0));
    check("t4_wr_rsp",     64'(rsp_valid), 64'(1));
    check("t4_wr_rdata",   64'(rsp_rdata), 64'(last_rdata));
    @(posedge clk_in); #1;
    check("t4_idle_ready", 64'(req_ready),  64'(1));
    check("t4_idle_norsp", 64'(rsp_valid),  64'(0));
    check("t4_idle_noen",  64'(bus_enable), 64'(0));
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    check("t4_busy_rd",   64'(req_ready),  64'(0));
    check("t4_rd_fetch",  64'(bus_enable), 64'(6'b000001));
    @(posedge clk_in); #1;
    check("t4_rd_capt",   64'(bus_enable), 64'(6'b000001));
    @(posedge clk_in); #1;
    check("t4_rd_rsp",    64'(rsp_valid),  64'(1));
    check("t4_rd_rdata",  64'(rsp_rdata),  64'(32'h11));
    @(posedge clk_in); #1;
    check("t4_rd_pulse_end", 64'(rsp_valid), 64'(0));
    exp_mem[0] = 32'h11;
    last_rdata = 32'h11;

    // T5a: reset during RD_CAPT.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2;
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    @(posedge clk_in); #1;
    check("t5_capt_enable", 64'(bus_enable), 64'(6'b000100));
    #2 rst_n_in = 1'b0;
    #1;
    check("t5_rst_enable", 64'(bus_enable), 64'(0));
    check("t5_rst_rsp",    64'(rsp_valid),  64'(0));
    check("t5_rst_rdata",  64'(rsp_rdata),  64'(0));
    @(posedge clk_in);
    @(negedge clk_in) rst_n_in = 1'b1;
    repeat (3) begin
      @(posedge clk_in); #1;
      check("t5_no_rsp", 64'(rsp_valid), 64'(0));
    end
    last_rdata = '0;

    // T5b: reset during WR must leave the old register value intact.
    do_req("t5_wr_a1_old", 1'b1, 3'd1, 32'h1234_5678, 1'b0, 32'h0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd1; req_wdata = 32'h55;
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    check("t5_wr_enable", 64'(bus_enable),   64'(6'b000010));
    check("t5_wr_data",   64'(bus_data_out), 64'(32'h55));
    #2 rst_n_in = 1'b0;
    #1;
    check("t5_wrrst_enable", 64'(bus_enable),   64'(0));
    check("t5_wrrst_write",  64'(bus_write),    64'(0));
    check("t5_wrrst_data",   64'(bus_data_out), 64'(0));
    @(posedge clk_in);
    @(negedge clk_in) rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    last_rdata = '0;
    do_req("t5_rd_a1", 1'b0, 3'd1, 32'h0, 1'b0, 32'h1234_5678);

    // T6: random traffic against the scoreboard.
    for (int n = 0; n < 500; n++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = AW'($urandom_range(0, 7));
      wdata = $urandom;
      err   = (int'(addr) >= NR);
      do_req("t6", wr, addr, wdata, err, err ? 32'h0 : exp_mem[addr]);
    end

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
